// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and bus-side signals of the IF/MEM memory port arbiter.
// Signal suffixes are from the arbiter's point of view.
interface mem_port_arbiter_if;
    logic        inst_req_i;
    logic [31:0] inst_addr_i;
    logic [31:0] inst_rdata_o;
    logic        inst_stall_o;

    logic        data_req_i;
    logic        data_wr_i;
    logic [1:0]  data_size_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_stall_o;

    logic        pipe_stall_i;
    logic        flush_i;

    logic        bus_req_o;
    logic        bus_wr_o;
    logic [1:0]  bus_size_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_addr_ok_i;
    logic        bus_data_ok_i;
    logic [31:0] bus_rdata_i;

    modport slave (
        input  inst_req_i, inst_addr_i,
        output inst_rdata_o, inst_stall_o,
        input  data_req_i, data_wr_i, data_size_i, data_addr_i, data_wdata_i,
        output data_rdata_o, data_stall_o,
        input  pipe_stall_i, flush_i,
        output bus_req_o, bus_wr_o, bus_size_o, bus_addr_o, bus_wdata_o,
        input  bus_addr_ok_i, bus_data_ok_i, bus_rdata_i
    );

    modport master (
        output inst_req_i, inst_addr_i,
        input  inst_rdata_o, inst_stall_o,
        output data_req_i, data_wr_i, data_size_i, data_addr_i, data_wdata_i,
        input  data_rdata_o, data_stall_o,
        output pipe_stall_i, flush_i,
        input  bus_req_o, bus_wr_o, bus_size_o, bus_addr_o, bus_wdata_o,
        output bus_addr_ok_i, bus_data_ok_i, bus_rdata_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one SRAM-like bus, data first,
// one outstanding transaction, and holds each returned word until the pipe advances.
module mem_port_arbiter (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  port
);
    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_e;
    typedef enum logic       {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_e;

    state_e      state_q;
    owner_e      owner_q;
    logic        discard_q;
    logic        bus_req_q;
    logic        bus_wr_q;
    logic [1:0]  bus_size_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic        inst_done_q;
    logic        data_done_q;
    logic [31:0] inst_buf_q;
    logic [31:0] data_buf_q;

    logic inst_pend;
    logic data_pend;
    logic drop_result;

    assign inst_pend   = port.inst_req_i & ~inst_done_q & ~port.flush_i;
    assign data_pend   = port.data_req_i & ~data_done_q & ~port.flush_i;
    // A flush arriving together with the response must already drop it.
    assign drop_result = discard_q | port.flush_i;

    // NOTE: every register here is written with <= so all reads in this block
    // see the pre-edge values, exactly like the flops they become.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_INST;
            discard_q   <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_wr_q    <= 1'b0;
            bus_size_q  <= 2'd0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            inst_done_q <= 1'b0;
            data_done_q <= 1'b0;
            inst_buf_q  <= 32'd0;
            data_buf_q  <= 32'd0;
        end else begin
            if (!port.pipe_stall_i || port.flush_i) begin
                inst_done_q <= 1'b0;
                data_done_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (data_pend) begin
                        owner_q     <= OWN_DATA;
                        bus_wr_q    <= port.data_wr_i;
                        bus_size_q  <= port.data_size_i;
                        bus_addr_q  <= port.data_addr_i;
                        bus_wdata_q <= port.data_wdata_i;
                        discard_q   <= 1'b0;
                        bus_req_q   <= 1'b1;
                        state_q     <= ADDR;
                    end else if (inst_pend) begin
                        owner_q     <= OWN_INST;
                        bus_wr_q    <= 1'b0;
                        bus_size_q  <= 2'd2;
                        bus_addr_q  <= port.inst_addr_i;
                        bus_wdata_q <= 32'd0;
                        discard_q   <= 1'b0;
                        bus_req_q   <= 1'b1;
                        state_q     <= ADDR;
                    end
                end
                ADDR: begin
                    if (port.flush_i) discard_q <= 1'b1;
                    if (port.bus_addr_ok_i) begin
                        bus_req_q <= 1'b0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (port.flush_i) discard_q <= 1'b1;
                    // A completing response wins over the done clear above.
                    if (port.bus_data_ok_i) begin
                        state_q <= IDLE;
                        if (!drop_result) begin
                            if (owner_q == OWN_DATA) begin
                                data_done_q <= 1'b1;
                                data_buf_q  <= port.bus_rdata_i;
                            end else begin
                                inst_done_q <= 1'b1;
                                inst_buf_q  <= port.bus_rdata_i;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign port.inst_stall_o = port.inst_req_i & ~inst_done_q;
    assign port.data_stall_o = port.data_req_i & ~data_done_q;
    assign port.inst_rdata_o = inst_buf_q;
    assign port.data_rdata_o = data_buf_q;
    assign port.bus_req_o    = bus_req_q;
    assign port.bus_wr_o     = bus_wr_q;
    assign port.bus_size_o   = bus_size_q;
    assign port.bus_addr_o   = bus_addr_q;
    assign port.bus_wdata_o  = bus_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic, all checked every cycle against a
// transaction-level reference of the arbiter kept in the bench.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    logic hold;

    mem_port_arbiter_if port_if ();

    mem_port_arbiter dut (
        .clk  (clk),
        .rst  (rst),
        .port (port_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          is_data;
        bit          wr;
        bit [1:0]    size;
        bit [31:0]   addr;
        bit [31:0]   wdata;
        bit          accepted;
        bit          dropped;
    } txn_t;

    // Reference: at most one transaction in flight; it is "accepted" once the
    // bus has taken the address, and "dropped" once a flush has hit it.
    txn_t     cur;
    txn_t     outstanding[$];
    bit       m_idone, m_ddone;
    bit [31:0] m_ibuf, m_dbuf;
    bit       m_advanced;

    int n_cmp;
    int n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        outstanding.delete();
        cur = '{default: '0};
        m_idone = 0; m_ddone = 0;
        m_ibuf = '0; m_dbuf = '0;
        m_advanced = 0;
    endtask

    function automatic bit exp_istall();
        return port_if.inst_req_i & ~m_idone;
    endfunction

    function automatic bit exp_dstall();
        return port_if.data_req_i & ~m_ddone;
    endfunction

    // Applies the rules of one clock edge using the inputs that were present at it.
    task automatic model_edge();
        bit   fl, pend_i, pend_d;
        txn_t t;
        fl     = port_if.flush_i;
        pend_i = port_if.inst_req_i & ~m_idone & ~fl;
        pend_d = port_if.data_req_i & ~m_ddone & ~fl;
        m_advanced = !port_if.pipe_stall_i;
        if (!port_if.pipe_stall_i || fl) begin
            m_idone = 0;
            m_ddone = 0;
        end
        if (outstanding.size() == 0) begin
            if (pend_d) begin
                t = '{1'b1, port_if.data_wr_i, port_if.data_size_i, port_if.data_addr_i,
                      port_if.data_wdata_i, 1'b0, 1'b0};
                outstanding.push_back(t);
                cur = t;
            end else if (pend_i) begin
                t = '{1'b0, 1'b0, 2'd2, port_if.inst_addr_i, 32'd0, 1'b0, 1'b0};
                outstanding.push_back(t);
                cur = t;
            end
        end else if (!outstanding[0].accepted) begin
            t = outstanding.pop_front();
            if (fl) t.dropped = 1;
            if (port_if.bus_addr_ok_i) t.accepted = 1;
            outstanding.push_front(t);
        end else begin
            t = outstanding.pop_front();
            if (fl) t.dropped = 1;
            if (!port_if.bus_data_ok_i) begin
                outstanding.push_front(t);
            end else if (!t.dropped) begin
                if (t.is_data) begin
                    m_ddone = 1; m_dbuf = port_if.bus_rdata_i;
                end else begin
                    m_idone = 1; m_ibuf = port_if.bus_rdata_i;
                end
            end
        end
    endtask

    task automatic check_all(input bit all_bus);
        bit breq;
        breq = (outstanding.size() != 0) && !outstanding[0].accepted;
        check("inst_stall", port_if.inst_stall_o, exp_istall());
        check("data_stall", port_if.data_stall_o, exp_dstall());
        check("inst_rdata", port_if.inst_rdata_o, m_ibuf);
        check("data_rdata", port_if.data_rdata_o, m_dbuf);
        check("bus_req", port_if.bus_req_o, breq);
        if (breq || all_bus) begin
            check("bus_addr", port_if.bus_addr_o, cur.addr);
            check("bus_size", port_if.bus_size_o, cur.size);
            check("bus_wr", port_if.bus_wr_o, cur.wr);
            if (cur.wr || all_bus) check("bus_wdata", port_if.bus_wdata_o, cur.wdata);
        end
    endtask

    // Called at a falling edge with inputs set; checks, runs one clock, returns at next falling edge.
    task automatic step();
        port_if.pipe_stall_i = exp_istall() | exp_dstall() | hold;
        #1;
        check_all(1'b0);
        @(posedge clk);
        #1;
        if (rst) model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        port_if.inst_req_i = 0; port_if.data_req_i = 0;
        port_if.flush_i = 0; hold = 0;
        port_if.bus_addr_ok_i = 1; port_if.bus_data_ok_i = 1;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rand_inputs();
        if (m_advanced || $urandom_range(7) == 0) begin
            port_if.inst_req_i   = ($urandom_range(3) != 0);
            port_if.inst_addr_i  = $urandom & 32'hFFFF_FFFC;
            port_if.data_req_i   = ($urandom_range(2) == 0);
            port_if.data_wr_i    = $urandom_range(1);
            port_if.data_size_i  = 2'($urandom_range(2));
            port_if.data_addr_i  = $urandom;
            port_if.data_wdata_i = $urandom;
        end
        port_if.flush_i       = ($urandom_range(15) == 0);
        hold                  = ($urandom_range(3) == 0);
        port_if.bus_addr_ok_i = $urandom_range(1);
        port_if.bus_data_ok_i = $urandom_range(1);
        port_if.bus_rdata_i   = $urandom;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 0; hold = 0;
        port_if.inst_req_i = 0; port_if.inst_addr_i = '0;
        port_if.data_req_i = 0; port_if.data_wr_i = 0; port_if.data_size_i = '0;
        port_if.data_addr_i = '0; port_if.data_wdata_i = '0;
        port_if.pipe_stall_i = 0; port_if.flush_i = 0;
        port_if.bus_addr_ok_i = 0; port_if.bus_data_ok_i = 0; port_if.bus_rdata_i = '0;
        model_reset();
        @(negedge clk);
        #1;
        check_all(1'b1);
        @(negedge clk);
        rst = 1;

        // Lone fetch with an immediately responding bus.
        port_if.inst_req_i = 1; port_if.inst_addr_i = 32'hBFC0_0000;
        port_if.bus_addr_ok_i = 1; port_if.bus_data_ok_i = 1;
        port_if.bus_rdata_i = 32'h2408_0001;
        step();
        check("fetch_bus_req_c1", port_if.bus_req_o, 1);
        check("fetch_addr_c1", port_if.bus_addr_o, 32'hBFC0_0000);
        step(); step();
        check("fetch_word", port_if.inst_rdata_o, 32'h2408_0001);
        check("fetch_stall_c3", port_if.inst_stall_o, 0);
        step();
        idle(3);

        // Flush while the fetch is in its data phase.
        port_if.inst_req_i = 1; port_if.inst_addr_i = 32'hBFC0_0008;
        port_if.bus_data_ok_i = 0; port_if.bus_rdata_i = 32'h1111_1111;
        step(); step();
        port_if.flush_i = 1; step();
        port_if.flush_i = 0; step();
        port_if.bus_data_ok_i = 1; step();
        check("flush_rdata_kept", port_if.inst_rdata_o, 32'h2408_0001);
        check("flush_still_stalled", port_if.inst_stall_o, 1);
        port_if.bus_rdata_i = 32'h2222_2222;
        step(); step(); step();
        check("after_flush_word", port_if.inst_rdata_o, 32'h2222_2222);
        idle(3);

        // Simultaneous fetch and byte load: data goes first.
        port_if.inst_req_i = 1; port_if.inst_addr_i = 32'hBFC0_0010;
        port_if.data_req_i = 1; port_if.data_wr_i = 0; port_if.data_size_i = 2'd0;
        port_if.data_addr_i = 32'h8000_0010; port_if.bus_rdata_i = 32'hA5A5_A5A5;
        step();
        check("sim_first_addr", port_if.bus_addr_o, 32'h8000_0010);
        check("sim_first_size", port_if.bus_size_o, 0);
        step(); step();
        check("sim_data_done", port_if.data_stall_o, 0);
        check("sim_inst_wait", port_if.inst_stall_o, 1);
        step();
        check("sim_second_addr", port_if.bus_addr_o, 32'hBFC0_0010);
        step(); step();
        check("sim_inst_done", port_if.inst_stall_o, 0);
        step();
        idle(3);

        // Store with the address phase held off for four cycles.
        port_if.data_req_i = 1; port_if.data_wr_i = 1; port_if.data_size_i = 2'd2;
        port_if.data_addr_i = 32'h8000_0020; port_if.data_wdata_i = 32'hDEAD_BEEF;
        port_if.bus_addr_ok_i = 0;
        step(); step(); step(); step();
        check("store_req_held", port_if.bus_req_o, 1);
        check("store_wdata", port_if.bus_wdata_o, 32'hDEAD_BEEF);
        port_if.bus_addr_ok_i = 1;
        step(); step();
        check("store_done", port_if.data_stall_o, 0);
        step();
        idle(3);

        // Completed fetch held under an external stall, then released.
        port_if.inst_req_i = 1; port_if.inst_addr_i = 32'hBFC0_000C;
        port_if.bus_rdata_i = 32'h3333_3333;
        step(); step(); step();
        hold = 1;
        for (int i = 0; i < 5; i++) step();
        check("hold_word", port_if.inst_rdata_o, 32'h3333_3333);
        check("hold_no_req", port_if.bus_req_o, 0);
        hold = 0; step();
        check("release_new_req", port_if.inst_stall_o, 1);
        idle(5);

        // Reset asserted during the address phase.
        port_if.inst_req_i = 1; port_if.inst_addr_i = 32'hBFC0_0014;
        port_if.bus_addr_ok_i = 0;
        step();
        rst = 0;
        #1;
        model_reset();
        check_all(1'b1);
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 3; i++) step();
        idle(5);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one SRAM-like memory bus between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the five-stage core. Serialises at most one outstanding bus transaction, with data priority over fetch. Drives the IF and MEM stall requests consumed by the hazard unit. Holds each returned word until the pipeline advances.

## Interface

Parameters: none (32-bit address and data fixed).

Ports:

- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `inst_req`  in  1  IF wants the word at `inst_addr`; held until the pipeline advances.
- `inst_addr`  in  32  fetch address (current PC).
- `inst_rdata`  out  32  fetched word (buffer register).
- `inst_stall`  out  1  stall request from IF.
- `data_req`  in  1  MEM wants a load or store; held until the pipeline advances.
- `data_wr`  in  1  1 = store, 0 = load.
- `data_size`  in  2  0 = byte, 1 = half, 2 = word.
- `data_addr`  in  32  data address.
- `data_wdata`  in  32  store data, already lane-aligned.
- `data_rdata`  out  32  load word (buffer register).
- `data_stall`  out  1  stall request from MEM.
- `pipe_stall`  in  1  OR of all stage stalls from the hazard unit (includes this block's stalls).
- `flush`  in  1  exception/eret flush; pending results are dropped.
- `bus_req`  out  1  bus request.
- `bus_wr`  out  1  bus write.
- `bus_size`  out  2  bus size.
- `bus_addr`  out  32  bus address.
- `bus_wdata`  out  32  bus write data.
- `bus_addr_ok`  in  1  request accepted this cycle.
- `bus_data_ok`  in  1  response this cycle; `bus_rdata` valid.
- `bus_rdata`  in  32  read data.

## Operation

State machine: IDLE, ADDR, DATA.

Per-side registers:
- `done` flag.
- 32-bit result buffer.
- Transaction fields (`owner`, `wr`, `size`, `addr`, `wdata`) and a `discard` flag.

Behaviour:
- pending_x = x_req & ~x_done & ~flush.
- **IDLE**: if data pending, grant data; else if inst pending, grant inst. Inst grant uses wr=0, size=2. Latch fields and owner, clear `discard`, go to ADDR. With nothing pending, stay in IDLE.
- **ADDR**: `bus_req`=1 and bus_* driven from the latched fields. On `bus_addr_ok`, go to DATA. Request fields never change while in ADDR.
- **DATA**: `bus_req`=0. On `bus_data_ok`, go to IDLE. Unless `discard` is set, the owner's `done` is set and its buffer gets `bus_rdata` (stores also set `done`; buffer gets `bus_rdata`).
- **flush**: clears both `done` flags. If state is not IDLE, sets `discard`. An in-flight transaction always completes on the bus; it is never abandoned.
- **Done clear**: each edge with `pipe_stall`=0 clears both `done` flags. A still-high `x_req` next cycle is a new request.
- **Stalls**: `inst_stall` = inst_req & ~inst_done; `data_stall` = data_req & ~data_done. Both are combinational from registers and inputs.
- **Rdata**: `inst_rdata`/`data_rdata` come straight from the buffers. They hold their value until overwritten by the next completed transaction for that side.

## Timing

- Reset values: state IDLE, `bus_req`=0, `bus_wr`=0, `bus_size`=0, `bus_addr`=0, `bus_wdata`=0, both `done`=0, both buffers 0, `discard`=0.
- Minimum latency with `addr_ok` and `data_ok` returned immediately:
  - cycle 0: request seen in IDLE.
  - cycle 1: ADDR, accepted.
  - cycle 2: DATA, response.
  - cycle 3: `done`=1, stall low, buffer valid.
- So a lone request stalls for 3 cycles.
- Both requesters pending in IDLE: data is served first, then inst. Inst stays stalled throughout.
- `addr_ok` asserted in DATA or IDLE is ignored. `data_ok` outside DATA is ignored.
- `flush` in the same cycle as `data_ok`: result discarded, `done` stays 0.
- `rst` low mid-transaction: immediate return to reset values. The bus slave is reset together with this block.
- A requester dropping `x_req` while it is the owner does not cancel the transaction. The result lands in the buffer, and `done` is later cleared by `pipe_stall`=0.

## Test plan

- **Lone fetch**: inst_req=1, inst_addr=0xBFC00000, immediate addr_ok and data_ok, bus_rdata=0x24080001 → bus_req=1 in cycle 1 only with bus_addr=0xBFC00000, size 2; inst_stall high cycles 0–2, low cycle 3; inst_rdata=0x24080001.
- **Simultaneous requests**: inst_req and a data load (addr 0x80000010, size 0) raised in the same cycle → first bus_req carries 0x80000010 with wr=0, size 0; second carries the inst address; data_stall falls 3 cycles before inst_stall.
- **Store**: data_wr=1, data_wdata=0xDEADBEEF, addr_ok delayed 4 cycles → bus_req held 4 cycles with bus_wdata stable and bus_wr=1; data_stall drops the cycle after data_ok.
- **Flush mid-transaction**: flush pulse while in DATA, data_ok 2 cycles later with bus_rdata=0x11111111 → inst_done stays 0, inst_rdata unchanged, state returns to IDLE, the next request is issued normally.
- **Hold under stall**: pipe_stall held high 5 cycles after a fetch completes → inst_stall stays low, inst_rdata stable, no new bus_req; first edge with pipe_stall=0 clears done.
- **Reset mid-transaction**: rst low during ADDR → bus_req=0 immediately, all outputs at reset values, no done set after rst returns high.
